// File: rtl/shift_register_pkg.sv
// Shared constants and width helper for the serial-in/parallel-out shift register.
// Latency: n/a (constants only). Backpressure: n/a.
package shift_register_pkg;

  localparam int DEFAULT_LENGTH   = 8;
  localparam int SHIFT_TOWARD_MSB = 0;
  localparam int SHIFT_TOWARD_LSB = 1;

  // Bits needed to hold a population count of 0..len.
  function automatic int count_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/shift_register_popcount.sv
// Combinational population count of a LENGTH-bit vector.
// Latency: zero cycles (pure combinational). Backpressure: none.
module shift_register_popcount
  import shift_register_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH
) (
  input  logic [LENGTH-1:0]                vec,
  output logic [count_width(LENGTH)-1:0]   count
);

  localparam int CW = count_width(LENGTH);

  always_comb begin
    count = '0;
    for (int i = 0; i < LENGTH; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/shift_register.sv
// Serial-in shift register with parallel state and serial-out tap; stats ports under SHIFT_REGISTER_STATS_EN.
// Latency: d reaches entry bit after 1 edge, q after LENGTH edges. Backpressure: none, shifts every non-reset edge.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int                 LENGTH      = DEFAULT_LENGTH,
  parameter int                 SHIFT_DIR   = SHIFT_TOWARD_MSB,
  parameter logic [LENGTH-1:0]  RESET_VALUE = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              d,
  output logic [LENGTH-1:0]                 state,
  output logic                              q
`ifdef SHIFT_REGISTER_STATS_EN
  ,
  output logic [count_width(LENGTH)-1:0]    ones_count,
  output logic                              parity
`endif
);

  generate
    if (LENGTH < 2 || LENGTH > 64) begin : g_bad_length
      $fatal(1, "shift_register: LENGTH=%0d outside 2..64", LENGTH);
    end
    if (SHIFT_DIR != SHIFT_TOWARD_MSB && SHIFT_DIR != SHIFT_TOWARD_LSB) begin : g_bad_dir
      $fatal(1, "shift_register: SHIFT_DIR=%0d must be 0 or 1", SHIFT_DIR);
    end
  endgenerate

  // Reset wins over shifting; d is ignored on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_VALUE;
    end else if (SHIFT_DIR == SHIFT_TOWARD_MSB) begin
      state <= {state[LENGTH-2:0], d};
    end else begin
      state <= {d, state[LENGTH-1:1]};
    end
  end

  assign q = (SHIFT_DIR == SHIFT_TOWARD_MSB) ? state[LENGTH-1] : state[0];

`ifdef SHIFT_REGISTER_STATS_EN
  shift_register_popcount #(
    .LENGTH (LENGTH)
  ) u_popcount (
    .vec   (state),
    .count (ones_count)
  );

  assign parity = ^state;
`endif

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench: three shift_register configurations driven by directed then random serial streams.
module tb_shift_register;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d   = 1'b0;

  always #10 clk = ~clk;

  logic [7:0] s8;  logic q8;
  logic [3:0] s4;  logic q4;
  logic [5:0] s6;  logic q6;
`ifdef SHIFT_REGISTER_STATS_EN
  logic [3:0] o8;  logic p8;
  logic [2:0] o4;  logic p4;
  logic [2:0] o6;  logic p6;
`endif

  localparam logic [7:0] RV8 = 8'h00;
  localparam logic [3:0] RV4 = 4'h0;
  localparam logic [5:0] RV6 = 6'b100101;

  shift_register #(.LENGTH(8), .SHIFT_DIR(0), .RESET_VALUE(RV8)) u_dut8 (
    .clk(clk), .rst(rst), .d(d), .state(s8), .q(q8)
`ifdef SHIFT_REGISTER_STATS_EN
    , .ones_count(o8), .parity(p8)
`endif
  );

  shift_register #(.LENGTH(4), .SHIFT_DIR(1), .RESET_VALUE(RV4)) u_dut4 (
    .clk(clk), .rst(rst), .d(d), .state(s4), .q(q4)
`ifdef SHIFT_REGISTER_STATS_EN
    , .ones_count(o4), .parity(p4)
`endif
  );

  shift_register #(.LENGTH(6), .SHIFT_DIR(0), .RESET_VALUE(RV6)) u_dut6 (
    .clk(clk), .rst(rst), .d(d), .state(s6), .q(q6)
`ifdef SHIFT_REGISTER_STATS_EN
    , .ones_count(o6), .parity(p6)
`endif
  );

  typedef struct {
    logic [7:0] s8; logic q8; int o8; logic p8;
    logic [3:0] s4; logic q4; int o4; logic p4;
    logic [5:0] s6; logic q6; int o6; logic p6;
  } exp_t;

  exp_t sbq[$];
  bit   hist[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference: bit at distance 'age' from the entry bit holds the input taken 'age' edges ago;
  // positions not yet reached since reset still hold the (shifted) reset value.
  function automatic logic [63:0] model(input int len, input int dir, input logic [63:0] rv,
                                        input bit h[$]);
    logic [63:0] r;
    int n, age;
    r = '0;
    n = h.size();
    for (int i = 0; i < len; i++) begin
      age = (dir == 0) ? i : len - 1 - i;
      if (age < n) r[i] = h[n - 1 - age];
      else         r[i] = (dir == 0) ? rv[i - n] : rv[i + n];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input bit dv, input bit rv, input bit gd, input bit gr);
    exp_t e;
    logic [63:0] m;
    @(negedge clk);
    d = dv;
    rst = rv;
    if (gd || gr) begin
      #2;
      if (gd) d = ~dv;
      if (gr) rst = ~rv;
      #5;
      d = dv;
      rst = rv;
    end
    if (rv) hist.delete();
    else begin
      hist.push_back(dv);
      if (hist.size() > 64) void'(hist.pop_front());
    end
    m = model(8, 0, 64'(RV8), hist);
    e.s8 = m[7:0]; e.q8 = m[7]; e.o8 = $countones(m[7:0]); e.p8 = ^m[7:0];
    m = model(4, 1, 64'(RV4), hist);
    e.s4 = m[3:0]; e.q4 = m[0]; e.o4 = $countones(m[3:0]); e.p4 = ^m[3:0];
    m = model(6, 0, 64'(RV6), hist);
    e.s6 = m[5:0]; e.q6 = m[5]; e.o6 = $countones(m[5:0]); e.p6 = ^m[5:0];
    sbq.push_back(e);
  endtask

  // Monitor: outputs are presented after every edge, so one expectation is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("state8", 64'(s8), 64'(e.s8));
        chk("q8",     64'(q8), 64'(e.q8));
        chk("state4", 64'(s4), 64'(e.s4));
        chk("q4",     64'(q4), 64'(e.q4));
        chk("state6", 64'(s6), 64'(e.s6));
        chk("q6",     64'(q6), 64'(e.q6));
`ifdef SHIFT_REGISTER_STATS_EN
        chk("ones8",  64'(o8), 64'(e.o8));
        chk("par8",   64'(p8), 64'(e.p8));
        chk("ones4",  64'(o4), 64'(e.o4));
        chk("par4",   64'(p4), 64'(e.p4));
        chk("ones6",  64'(o6), 64'(e.o6));
        chk("par6",   64'(p6), 64'(e.p6));
`endif
      end
    end
  end

  initial begin
    // reset, then single pulse walking through the register
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0);
    // fill then partial drain
    step(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    // mid-stream reset with d high, then resume
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    // glitches on d and rst between edges
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    // random stream with occasional resets and glitches
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #5;
    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
